fetch_queue: RTL

- Decoupling FIFO between the fetch stage and the issue stage; it replaces the single fetch_issue pipeline register.
- Buffers up to DEPTH fetched instruction packets (pipe_in_t) so fetch can keep running while issue stalls on full RS/ROB/LSQ.
- Presents the oldest packet to rs_scheduler / new_pc.
- Flushed completely on branch mispredict, or when issue redirects on a predicted-taken branch.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue.sv | 65 ++++++
 2 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/issue structures and fetch queue sizing constants.
package fetch_queue_pkg;

    // Packet handed from fetch to issue; opaque to the queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        prediction;
        logic [31:0] target;
    } pipe_in_t;

    localparam int FQ_DEPTH    = 4;
    localparam int FQ_AF_LEVEL = 3;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and issue; no bypass, so an empty-queue
// enqueue shows up on deq_* one cycle later, like the old pipeline register.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH    = FQ_DEPTH,
    parameter  int AF_LEVEL = FQ_AF_LEVEL,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           enq_valid,
    input  pipe_in_t       enq_pkt,
    output logic           enq_ready,
    output logic           deq_valid,
    output pipe_in_t       deq_pkt,
    input  logic           deq_ready,
    output logic [PTR_W:0] count,
    output logic           almost_full,
    output logic           empty
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] AF_CNT  = (PTR_W + 1)'(AF_LEVEL);

    pipe_in_t       mem [DEPTH];
    logic [PTR_W:0] head;
    logic [PTR_W:0] tail;
    logic           full;
    logic           enq_fire;
    logic           deq_fire;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full  = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
    assign empty = (head == tail);
    assign count = tail - head;

    assign enq_ready   = ~full;
    assign deq_valid   = ~empty;
    assign almost_full = (count >= AF_CNT);
    assign deq_pkt     = empty ? pipe_in_t'('0) : mem[head[PTR_W-1:0]];

    assign enq_fire = enq_valid & ~full;
    assign deq_fire = deq_ready & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) tail <= tail + PTR_ONE;
            if (deq_fire) head <= head + PTR_ONE;
        end
    end

    // Storage is never cleared; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) mem[tail[PTR_W-1:0]] <= enq_pkt;
    end

endmodule
